// File: rtl/act_bit_packer.sv
// Packs binarized activations into PW-bit feature-map RAM words.
// Build option: ACT_PACK_MSB_FIRST_EN selects MSB-first bit placement.
module act_bit_packer #(
  parameter int PW = 16,
  parameter int AW = 10,
  parameter int LW = 16
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSTART,
  input  logic [LW-1:0] iLEN,
  input  logic [AW-1:0] iBASE,
  input  logic          iEN,
  input  logic          iDATA,
  output logic          oWR_EN,
  output logic [AW-1:0] oWR_ADDR,
  output logic [PW-1:0] oWR_DATA,
  output logic          oBUSY,
  output logic          oDONE,
  output logic          oERR
);

  localparam int IW = $clog2(PW);

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    LAST
  } state_t;

  state_t state, stateNext;

  logic [LW-1:0] len;
  logic [LW-1:0] bitCnt;
  logic [AW-1:0] addr;
  logic [IW-1:0] wIdx;
  logic [IW-1:0] pos;
  logic [PW-1:0] shreg;
  logic [PW-1:0] word;
  logic          take;
  logic          lastBit;
  logic          wordFull;
  logic          flush;
  logic          protoErr;
  logic          startOk;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic [PW-1:0] wrData;
  logic          done;
  logic          err;

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    take      = 1'b0;
    lastBit   = 1'b0;
    protoErr  = 1'b0;
    startOk   = 1'b0;
`ifdef ACT_PACK_MSB_FIRST_EN
    pos       = IW'(PW - 1) - wIdx;
`else
    pos       = wIdx;
`endif
    word      = shreg | (PW'(iDATA) << pos);
    wordFull  = (wIdx == IW'(PW - 1));
    unique case (state)
      IDLE: begin
        protoErr = iEN;
        if (iSTART) begin
          startOk   = 1'b1;
          stateNext = (iLEN == '0) ? LAST : PACK;
        end
      end
      PACK: begin
        protoErr = iSTART;
        if (iEN) begin
          take    = 1'b1;
          lastBit = ((bitCnt + LW'(1)) == len);
          if (lastBit) stateNext = LAST;
        end
      end
      LAST: begin
        protoErr  = iSTART | iEN;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    flush = take & (wordFull | lastBit);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      len    <= '0;
      bitCnt <= '0;
      addr   <= '0;
      wIdx   <= '0;
      shreg  <= '0;
      wrEn   <= 1'b0;
      wrAddr <= '0;
      wrData <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      wrEn <= flush;
      done <= (stateNext == LAST) && (state != LAST);
      err  <= err | protoErr;
      if (startOk) begin
        len    <= iLEN;
        addr   <= iBASE;
        bitCnt <= '0;
        wIdx   <= '0;
        shreg  <= '0;
      end
      if (take) begin
        bitCnt <= bitCnt + LW'(1);
        // a flushed word restarts from zero so padding is free
        if (flush) begin
          wrData <= word;
          wrAddr <= addr;
          addr   <= addr + AW'(1);
          shreg  <= '0;
          wIdx   <= '0;
        end else begin
          shreg <= word;
          wIdx  <= wIdx + IW'(1);
        end
      end
    end
  end

  assign oWR_EN   = wrEn;
  assign oWR_ADDR = wrAddr;
  assign oWR_DATA = wrData;
  assign oBUSY    = (state != IDLE);
  assign oDONE    = done;
  assign oERR     = err;

endmodule
